// File: rtl/qlf_fifo_pkg.sv
// rtl/qlf_fifo_pkg.sv - shared qlf FIFO types and constants
package qlf_fifo_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } fsm_state_t;

  localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/sfifo_skid_buf2.sv
// rtl/sfifo_skid_buf2.sv - 2-entry register FIFO holding words returned by the upstream FIFO
module sfifo_skid_buf2
  import qlf_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  clear,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            occ
);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic                  wr_ptr;
  logic                  rd_ptr;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (rd) rd_ptr <= ~rd_ptr;
      occ <= occ + {1'b0, wr} - {1'b0, rd};
    end
  end

  // Data storage is deliberately left unreset; occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (wr && !clear) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/sfifo_stream_adapter.sv
// rtl/sfifo_stream_adapter.sv - turns a pop/dout synchronous FIFO read port into a valid/ready stream
module sfifo_stream_adapter
  import qlf_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 36,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock0,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  input  logic                  fifo_underrun,
  output logic                  fifo_pop,
  output logic                  fifo_flush,
  input  logic                  flush_req,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic                  err_sticky,
  output logic                  busy
);

  fsm_state_t state;
  fsm_state_t state_next;
  logic       enter_flush;
  logic       inflight;
  logic [1:0] occ;
  logic       transfer;
  logic [2:0] committed;

  always_ff @(posedge clock0) begin
    if (!reset_n) state <= RUN;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    enter_flush = 1'b0;
    fifo_flush  = 1'b0;
    case (state)
      RUN: begin
        if (flush_req) begin
          state_next  = FLUSH;
          enter_flush = 1'b1;
        end
      end
      FLUSH: begin
        fifo_flush = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // occ is cleared on entry to FLUSH, so m_valid is already low there.
  assign m_valid  = (occ != 2'd0);
  assign transfer = m_valid & m_ready;

  // Slots already spoken for after this edge; a new pop must still fit.
  assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, transfer};
  assign fifo_pop  = reset_n & (state == RUN) & ~fifo_empty
                   & (committed < 3'(BUF_DEPTH));

  always_ff @(posedge clock0) begin
    if (!reset_n)         inflight <= 1'b0;
    else if (enter_flush) inflight <= 1'b0;
    else                  inflight <= fifo_pop;
  end

  always_ff @(posedge clock0) begin
    if (!reset_n)         word_count <= '0;
    else if (enter_flush) word_count <= '0;
    else if (transfer)    word_count <= word_count + 1'b1;
  end

  always_ff @(posedge clock0) begin
    if (!reset_n)           err_sticky <= 1'b0;
    else if (enter_flush)   err_sticky <= 1'b0;
    else if (fifo_underrun) err_sticky <= 1'b1;
  end

  sfifo_skid_buf2 #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk     (clock0),
    .reset_n (reset_n),
    .clear   (enter_flush),
    .wr      (inflight),
    .wr_data (fifo_dout),
    .rd      (transfer),
    .rd_data (m_data),
    .occ     (occ)
  );

  assign busy = m_valid | inflight | (state == FLUSH);

endmodule

// File: tb/tb_sfifo_stream_adapter.sv
// tb/tb_sfifo_stream_adapter.sv - self-checking bench for sfifo_stream_adapter
module tb_sfifo_stream_adapter;

  localparam int DW = 36;
  localparam int CW = 4;

  logic          clock0 = 1'b0;
  logic          reset_n;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_underrun;
  logic          fifo_pop;
  logic          fifo_flush;
  logic          flush_req;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic [CW-1:0] word_count;
  logic          err_sticky;
  logic          busy;

  always #5 clock0 = ~clock0;

  sfifo_stream_adapter #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clock0        (clock0),
    .reset_n       (reset_n),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .fifo_underrun (fifo_underrun),
    .fifo_pop      (fifo_pop),
    .fifo_flush    (fifo_flush),
    .flush_req     (flush_req),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .word_count    (word_count),
    .err_sticky    (err_sticky),
    .busy          (busy)
  );

  int checks   = 0;
  int failures = 0;

  // Upstream FIFO contents and the reference view of the adapter.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] ref_q[$];
  bit            ref_pend;
  bit            ref_flush;
  int            ref_cnt;
  bit            ref_err;

  bit            s_pop, s_xfer, s_flushreq, s_und, s_rstn, a_pop, a_fflush;
  logic [DW-1:0] s_dout;

  typedef struct {
    bit pop;
    bit valid;
    int idx;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic sample();
    bit e_valid, e_xfer, e_pop;
    @(negedge clock0);
    e_valid = (ref_q.size() != 0) && !ref_flush;
    e_xfer  = e_valid && m_ready;
    e_pop   = reset_n && !ref_flush && !fifo_empty
              && (ref_q.size() + int'(ref_pend) - int'(e_xfer) < 2);
    chk("m_valid", m_valid, e_valid);
    if (e_valid) chk("m_data", m_data, ref_q[0]);
    chk("fifo_pop", fifo_pop, e_pop);
    chk("fifo_flush", fifo_flush, ref_flush);
    chk("word_count", word_count, ref_cnt);
    chk("err_sticky", err_sticky, ref_err);
    chk("busy", busy, e_valid || ref_pend || ref_flush);
    s_pop      = e_pop;
    s_xfer     = e_xfer;
    s_dout     = fifo_dout;
    s_flushreq = flush_req;
    s_und      = fifo_underrun;
    s_rstn     = reset_n;
    a_pop      = fifo_pop;
    a_fflush   = fifo_flush;
  endtask

  task automatic ref_clear();
    ref_q.delete();
    ref_pend = 0;
    ref_cnt  = 0;
    ref_err  = 0;
  endtask

  task automatic edge_step();
    @(posedge clock0);
    #1;
    if (a_pop && fifo_q.size() != 0) fifo_dout = fifo_q.pop_front();
    else                             fifo_dout = rnd();
    if (!s_rstn || a_fflush) fifo_q.delete();
    fifo_empty = (fifo_q.size() == 0);
    if (!s_rstn) begin
      ref_clear();
      ref_flush = 0;
    end else if (!ref_flush && s_flushreq) begin
      ref_clear();
      ref_flush = 1;
    end else begin
      if (s_xfer) begin
        void'(ref_q.pop_front());
        ref_cnt = (ref_cnt + 1) % (1 << CW);
      end
      if (ref_pend) ref_q.push_back(s_dout);
      if (s_und) ref_err = 1;
      ref_pend  = s_pop;
      ref_flush = 0;
    end
  endtask

  task automatic cycle();
    sample();
    edge_step();
  endtask

  task automatic do_reset();
    m_ready = 0; flush_req = 0; fifo_underrun = 0;
    reset_n = 0;
    cycle();
    reset_n = 1;
  endtask

  vec_t          t31[7];
  logic [DW-1:0] w[5];
  logic [DW-1:0] first_seen;
  int            pops, n;
  bit            got_first;

  initial begin
    t31[0] = '{1, 0, 0}; t31[1] = '{1, 0, 0}; t31[2] = '{1, 1, 0}; t31[3] = '{1, 1, 1};
    t31[4] = '{0, 1, 2}; t31[5] = '{0, 1, 3}; t31[6] = '{0, 0, 0};

    reset_n = 0; fifo_empty = 1; fifo_underrun = 0; flush_req = 0; m_ready = 0;
    fifo_dout = '0;
    ref_clear(); ref_flush = 0;
    repeat (2) @(posedge clock0);
    #1;
    sample();
    chk("reset_m_valid", m_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_pop", fifo_pop, 0);
    chk("reset_flush", fifo_flush, 0);
    chk("reset_count", word_count, 0);
    chk("reset_err", err_sticky, 0);
    edge_step();
    reset_n = 1;

    // Four words streamed with m_ready held high.
    w[0] = 36'h0A000000A; w[1] = 36'h0B000000B; w[2] = 36'h0C000000C; w[3] = 36'h0D000000D;
    for (int i = 0; i < 4; i++) push(w[i]);
    m_ready = 1;
    for (int i = 0; i < 7; i++) begin
      sample();
      chk($sformatf("t31_pop[%0d]", i), fifo_pop, t31[i].pop);
      chk($sformatf("t31_valid[%0d]", i), m_valid, t31[i].valid);
      if (t31[i].valid) chk($sformatf("t31_data[%0d]", i), m_data, w[t31[i].idx]);
      edge_step();
    end
    sample(); chk("t31_count", word_count, 4); edge_step();

    // Backpressure: buffer fills to two, head held, then drains without a gap.
    do_reset();
    for (int i = 0; i < 3; i++) begin w[i] = rnd(); push(w[i]); end
    m_ready = 0; pops = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      pops += int'(fifo_pop);
      if (i >= 2) begin
        chk("r32_valid_hold", m_valid, 1);
        chk("r32_data_hold", m_data, w[0]);
      end
      edge_step();
    end
    chk("r32_pops", pops, 2);
    m_ready = 1;
    for (int i = 0; i < 4; i++) begin
      sample();
      chk($sformatf("r32_drain_valid[%0d]", i), m_valid, i < 3);
      if (i < 3) chk($sformatf("r32_drain_data[%0d]", i), m_data, w[i]);
      edge_step();
    end

    // Flush requested in a pop cycle; a second request during FLUSH is ignored.
    do_reset();
    for (int i = 0; i < 5; i++) push(rnd());
    m_ready = 1;
    for (int i = 0; i < 3; i++) cycle();
    flush_req = 1;
    sample();
    chk("r33_pop_same", fifo_pop, 1);
    chk("r33_count_pre", word_count, 1);
    edge_step();
    sample();
    chk("r33_flush", fifo_flush, 1);
    chk("r33_valid", m_valid, 0);
    chk("r33_nopop", fifo_pop, 0);
    chk("r33_count", word_count, 0);
    edge_step();
    flush_req = 0;
    sample();
    chk("r33_flush_once", fifo_flush, 0);
    chk("r33_dropped", m_valid, 0);
    chk("r33_idle", busy, 0);
    edge_step();
    for (int i = 0; i < 3; i++) begin
      sample(); chk("r33_no_word", m_valid, 0); edge_step();
    end

    // Underrun latch and its clear by flush.
    do_reset();
    fifo_underrun = 1;
    sample(); chk("r34_err_same", err_sticky, 0); edge_step();
    fifo_underrun = 0;
    for (int i = 0; i < 3; i++) begin
      sample(); chk("r34_err_held", err_sticky, 1); edge_step();
    end
    flush_req = 1;
    sample(); chk("r34_err_before_flush", err_sticky, 1); edge_step();
    flush_req = 0;
    sample(); chk("r34_err_cleared", err_sticky, 0); edge_step();

    // Counter wrap: 17 transfers on a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) push(rnd());
    m_ready = 1; n = 0;
    for (int i = 0; i < 40 && n < 17; i++) begin
      sample();
      n += int'(m_valid && m_ready);
      edge_step();
    end
    chk("r35_transfers", n, 17);
    sample(); chk("r35_count_wrap", word_count, 1); edge_step();

    // Mid-stream reset with a full buffer.
    do_reset();
    for (int i = 0; i < 5; i++) push(rnd());
    m_ready = 0;
    for (int i = 0; i < 4; i++) cycle();
    sample(); chk("r36_full", m_valid, 1); edge_step();
    reset_n = 0;
    cycle();
    reset_n = 1;
    sample();
    chk("r36_valid", m_valid, 0);
    chk("r36_busy", busy, 0);
    chk("r36_pop", fifo_pop, 0);
    chk("r36_flush", fifo_flush, 0);
    chk("r36_count", word_count, 0);
    chk("r36_err", err_sticky, 0);
    edge_step();
    w[4] = rnd(); push(w[4]); push(rnd());
    m_ready = 1; got_first = 0; first_seen = '0;
    for (int i = 0; i < 6; i++) begin
      sample();
      if (m_valid && !got_first) begin got_first = 1; first_seen = m_data; end
      edge_step();
    end
    chk("r36_first_new", first_seen, w[4]);
    chk("r36_seen", got_first, 1);

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      m_ready       = ($urandom_range(0, 9) < 7);
      flush_req     = ($urandom_range(0, 39) == 0);
      fifo_underrun = ($urandom_range(0, 49) == 0);
      reset_n       = ($urandom_range(0, 299) != 0);
      if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) push(rnd());
      cycle();
    end
    reset_n = 1; flush_req = 0; fifo_underrun = 0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sfifo_stream_adapter.md
SFIFO_STREAM_ADAPTER -- requirements
Module: sfifo_stream_adapter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 36, meaning the read-side width of the upstream synchronous FIFO and of the stream.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning the width of the delivered-word counter.
REQ-003 SHALL have clock0, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have fifo_dout, input, DATA_WIDTH bits: FIFO read data, valid exactly 1 cycle after a fifo_pop.
REQ-006 SHALL have fifo_empty, input, 1 bit: FIFO Empty flag, already updated for every pop taken on earlier edges.
REQ-007 SHALL have fifo_underrun, input, 1 bit: FIFO Underrun_Error.
REQ-008 SHALL have fifo_pop, output, 1 bit: POP to the FIFO.
REQ-009 SHALL have fifo_flush, output, 1 bit: Async_Flush to the FIFO.
REQ-010 SHALL have flush_req, input, 1 bit: single-cycle flush request.
REQ-011 SHALL have m_data, output, DATA_WIDTH bits; m_valid, output, 1 bit; m_ready, input, 1 bit: the downstream stream.
REQ-012 SHALL have word_count, output, CNT_WIDTH bits: stream transfers since reset or flush.
REQ-013 SHALL have err_sticky, output, 1 bit: latched underrun.
REQ-014 SHALL have busy, output, 1 bit: high when occ != 0, inflight = 1, or state is FLUSH.

Function
REQ-015 SHALL hold a 2-entry output buffer with occupancy occ (0..2) and an inflight bit (pop issued last cycle).
REQ-016 SHALL drive m_valid = (occ != 0), with m_data = buffer head, registered and glitch-free; a transfer is m_valid & m_ready.
REQ-017 SHALL drive fifo_pop = RUN & !fifo_empty & (occ + inflight - transfer < 2), combinational.
REQ-018 SHALL, when inflight = 1, write fifo_dout into the buffer tail on that edge; simultaneous write and transfer SHALL keep occ unchanged and preserve order.
REQ-019 SHALL sustain 1 word/cycle with m_ready held high, after a 2-cycle first-word latency (pop -> capture -> m_valid).
REQ-020 SHALL never overflow the buffer (occ + inflight <= 2 always), and SHALL keep m_data stable while m_valid & !m_ready.
REQ-021 SHALL use FSM states RUN and FLUSH: RUN -> FLUSH on flush_req; FLUSH -> RUN after exactly 1 cycle.
REQ-022 SHALL, in FLUSH, assert fifo_flush for 1 cycle, issue no pop, and force m_valid low.
REQ-023 SHALL, on entering FLUSH, clear occ, inflight, word_count and err_sticky, so that data returned for a pop issued in the flush_req cycle is discarded.
REQ-024 SHALL ignore a flush_req that arrives while already in FLUSH.
REQ-025 SHALL increment word_count on each transfer, wrapping from all-ones to 0.
REQ-026 SHALL set err_sticky on the cycle after fifo_underrun = 1, and hold it until flush or reset.

Reset
REQ-027 SHALL, while reset_n = 0 at an edge, set state = RUN, occ = 0, inflight = 0, word_count = 0 and err_sticky = 0, with fifo_pop, fifo_flush, m_valid and busy all 0.
REQ-028 SHALL discard data for any pop issued before a mid-operation reset, and SHALL leave buffer data contents unreset.

Structure
REQ-029 SHALL take the FSM state enum (RUN, FLUSH) and the buffer depth constant (2) from the shared qlf FIFO package.
REQ-030 SHALL implement the buffer as one sub-module, sfifo_skid_buf2 (2-entry register FIFO with wr/rd/occ); control and counters stay in the top level.

Verification
REQ-031 FIFO holds 4 words A..D, m_ready = 1 -> pops on cycles 0-3, m_valid on cycles 2-5 with A,B,C,D; word_count = 4.
REQ-032 FIFO holds 3 words, m_ready = 0 -> exactly 2 pops, occ = 2, m_data = first word held stable; m_ready = 1 -> remaining word follows with no gap.
REQ-033 flush_req in the same cycle as a pop -> fifo_flush high for 1 cycle, m_valid low, the returned word is dropped, word_count = 0.
REQ-034 fifo_underrun pulsed once -> err_sticky = 1 from the next cycle, held until flush_req.
REQ-035 CNT_WIDTH = 4, 17 transfers -> word_count = 1.
REQ-036 reset_n low for 1 cycle mid-stream with occ = 2 -> all outputs 0 on the next cycle, and no stale word appears afterwards.
